// File: rtl/rns_tc_pkg.sv
// Shared definitions for thermometer-coded RNS residues: op encoding and code helpers.
// Helpers work on a 64-bit carrier with the live width passed in; tc2bin/bin2tc serve checking code only.
package rns_tc_pkg;

  localparam int TC_MAXW = 64;

  typedef logic [TC_MAXW-1:0] tc_word_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } tc_op_e;

  function automatic tc_word_t tc_mask(input int w);
    return (tc_word_t'(1) << w) - tc_word_t'(1);
  endfunction

  // A legal code is a contiguous run of ones from bit 0 inside the live width.
  function automatic logic tc_is_valid(input tc_word_t x, input int w);
    return ((x & ~tc_mask(w)) == '0) && ((x & (x + tc_word_t'(1))) == '0);
  endfunction

  // Reversed complement alone encodes M-1-b; shifting in a one gives M-b, and b=0 maps to 0.
  function automatic tc_word_t tc_neg(input tc_word_t x, input int w);
    tc_word_t nx;
    tc_word_t rev;
    nx  = ~x;
    rev = {<<{nx}};
    rev = rev >> (TC_MAXW - w);
    return x[0] ? (((rev << 1) | tc_word_t'(1)) & tc_mask(w)) : '0;
  endfunction

  function automatic int tc2bin(input tc_word_t x);
    return $countones(x);
  endfunction

  function automatic tc_word_t bin2tc(input int v);
    return tc_mask(v);
  endfunction

endpackage

// File: rtl/tc_mod_add_core.sv
// Combinational thermometer adder mod MODULUS; builds the unwrapped sum code, then folds it back by M.
module tc_mod_add_core #(
  parameter int MODULUS = 11
) (
  input  logic [MODULUS-2:0] a,
  input  logic [MODULUS-2:0] b,
  output logic [MODULUS-2:0] sum
);
  localparam int W = MODULUS - 1;

  // Bit t of the extended operand means "value >= t"; bit 0 is always true.
  logic [2*W+1:0] a_ext;
  logic [2*W+1:0] b_ext;
  logic [2*W:0]   tot;

  assign a_ext = {{(W+1){1'b0}}, a, 1'b1};
  assign b_ext = {{(W+1){1'b0}}, b, 1'b1};

  always_comb begin
    tot = '0;
    for (int j = 0; j <= 2*W; j++) begin
      for (int t = 0; t <= j + 1; t++) begin
        tot[j] = tot[j] | (a_ext[t] & b_ext[j+1-t]);
      end
    end
    // tot[W] set means a+b >= M, so the residue is the part of the code above M.
    sum = tot[W] ? tot[2*W:W+1] : tot[W-1:0];
  end

endmodule

// File: rtl/tc_modulo_adder_pipe.sv
// Multi-lane thermometer RNS add/sub/accumulate; two register stages, 2-cycle latency.
// Valid/ready on both sides: stalls hold the output register and back-pressure S1 without bubbles.
module tc_modulo_adder_pipe
  import rns_tc_pkg::*;
#(
  parameter int MODULUS = 11,
  parameter int NCH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_op,
  input  logic [NCH*(MODULUS-1)-1:0]   in_a,
  input  logic [NCH*(MODULUS-1)-1:0]   in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NCH*(MODULUS-1)-1:0]   out_res,
  output logic [NCH-1:0]               out_err
);
  localparam int W = MODULUS - 1;

  typedef logic [NCH-1:0][W-1:0] lanes_t;

  logic           s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  tc_op_e         s1_op_q, s1_op_d, in_op_e;
  lanes_t         s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  lanes_t         s2_res_q, s2_res_d, acc_q, acc_d;
  logic [NCH-1:0] s1_err_q, s1_err_d, s2_err_q, s2_err_d;
  lanes_t         b_eff, op_sum, acc_sum;
  logic           s1_adv, in_fire, s2_load;

  assign in_op_e  = tc_op_e'(in_op);
  assign s1_adv   = !s2_v_q || out_ready;
  assign in_ready = !rst && (!s1_v_q || s1_adv);
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_v_q && s1_adv;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign b_eff[i] = (s1_op_q == OP_SUB) ? W'(tc_neg(TC_MAXW'(s1_b_q[i]), W)) : s1_b_q[i];

    tc_mod_add_core #(.MODULUS(MODULUS)) u_op_add (
      .a   (s1_a_q[i]),
      .b   (b_eff[i]),
      .sum (op_sum[i])
    );

    tc_mod_add_core #(.MODULUS(MODULUS)) u_acc_add (
      .a   (acc_q[i]),
      .b   (s1_a_q[i]),
      .sum (acc_sum[i])
    );
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_op_d  = s1_op_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_err_d = s1_err_q;
    if (in_fire) begin
      s1_v_d  = 1'b1;
      s1_op_d = in_op_e;
      s1_a_d  = in_a;
      s1_b_d  = in_b;
      for (int i = 0; i < NCH; i++) begin
        s1_err_d[i] = !tc_is_valid(TC_MAXW'(s1_a_d[i]), W) ||
                      (((in_op_e == OP_ADD) || (in_op_e == OP_SUB)) &&
                       !tc_is_valid(TC_MAXW'(s1_b_d[i]), W));
      end
      if (in_op_e == OP_CLR) s1_err_d = '0;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end
  end

  // The accumulator only moves when a transaction enters S2, so a stalled one never applies twice.
  always_comb begin
    s2_v_d   = s2_v_q;
    s2_res_d = s2_res_q;
    s2_err_d = s2_err_q;
    acc_d    = acc_q;
    if (s2_load) begin
      s2_v_d   = 1'b1;
      s2_err_d = s1_err_q;
      for (int i = 0; i < NCH; i++) begin
        case (s1_op_q)
          OP_ADD, OP_SUB: s2_res_d[i] = op_sum[i];
          OP_ACC: begin
            s2_res_d[i] = acc_sum[i];
            if (!s1_err_q[i]) acc_d[i] = acc_sum[i];
          end
          default: begin
            s2_res_d[i] = '0;
            acc_d[i]    = '0;
          end
        endcase
        if (s1_err_q[i]) s2_res_d[i] = '0;
      end
    end else if (out_ready) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_op_q  <= OP_ADD;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_err_q <= '0;
      s2_v_q   <= 1'b0;
      s2_res_q <= '0;
      s2_err_q <= '0;
      acc_q    <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_op_q  <= s1_op_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_err_q <= s1_err_d;
      s2_v_q   <= s2_v_d;
      s2_res_q <= s2_res_d;
      s2_err_q <= s2_err_d;
      acc_q    <= acc_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_res   = s2_res_q;
  assign out_err   = s2_err_q;

endmodule

// File: tb/tb_tc_modulo_adder_pipe.sv
// Bench for tc_modulo_adder_pipe: vector table, hand-built pipeline sequences and a
// random stream checked against an integer-arithmetic reference with a result queue.
module tb_tc_modulo_adder_pipe;
  import rns_tc_pkg::*;

  localparam int M   = 11;
  localparam int NCH = 4;
  localparam int W   = M - 1;

  typedef logic [NCH-1:0][W-1:0] lanes_t;
  typedef struct {
    lanes_t         res;
    logic [NCH-1:0] err;
  } exp_t;
  typedef struct {
    logic [1:0]          op;
    logic [NCH-1:0][7:0] a;
    logic [NCH-1:0][7:0] b;
    logic [NCH-1:0][7:0] r;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_op;
  logic [NCH*W-1:0]     in_a;
  logic [NCH*W-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*W-1:0]     out_res;
  logic [NCH-1:0]       out_err;

  int             checks = 0;
  int             errors = 0;
  int             n_out  = 0;
  int             acc_m[NCH];
  exp_t           sbq[$];
  logic           prev_stall = 1'b0;
  logic [NCH*W-1:0] prev_res;
  logic [NCH-1:0] prev_err;

  tc_modulo_adder_pipe #(.MODULUS(M), .NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic lanes_t tcl(input logic [NCH-1:0][7:0] v);
    lanes_t r;
    for (int i = 0; i < NCH; i++) r[i] = W'(bin2tc(int'(v[i])));
    return r;
  endfunction

  function automatic lanes_t splat(input int v);
    lanes_t r;
    for (int i = 0; i < NCH; i++) r[i] = W'(bin2tc(v));
    return r;
  endfunction

  function automatic logic [W-1:0] rlane();
    if ($urandom_range(0, 15) == 0) return W'($urandom);
    return W'(bin2tc(int'($urandom_range(0, M-1))));
  endfunction

  function automatic logic legal(input logic [W-1:0] x);
    return x == W'(bin2tc(tc2bin(TC_MAXW'(x))));
  endfunction

  // Reference: per-lane integer arithmetic in acceptance order.
  task automatic model(input logic [1:0] op, input lanes_t a, input lanes_t b, output exp_t e);
    int  av, bv, r;
    logic ok;
    e.res = '0;
    e.err = '0;
    for (int i = 0; i < NCH; i++) begin
      av = tc2bin(TC_MAXW'(a[i]));
      bv = tc2bin(TC_MAXW'(b[i]));
      ok = legal(a[i]) && ((op == OP_ACC) || (op == OP_CLR) || legal(b[i]));
      r  = 0;
      case (op)
        OP_ADD: r = (av + bv) % M;
        OP_SUB: r = (av - bv + M) % M;
        OP_ACC: begin
          r = (acc_m[i] + av) % M;
          if (ok) acc_m[i] = r;
        end
        default: begin
          r = 0;
          acc_m[i] = 0;
          ok = 1'b1;
        end
      endcase
      if (!ok) begin
        e.err[i] = 1'b1;
        r = 0;
      end
      e.res[i] = W'(bin2tc(r));
    end
  endtask

  task automatic smp();
    exp_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_hold_valid", 64'(out_valid), 64'(1'b1));
      chk("stall_hold_res", 64'(out_res), 64'(prev_res));
      chk("stall_hold_err", 64'(out_err), 64'(prev_err));
    end
    if (rst) begin
      sbq.delete();
      for (int i = 0; i < NCH; i++) acc_m[i] = 0;
      prev_stall = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'(1'b0));
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'(1'b0));
        end else begin
          e = sbq.pop_front();
          chk("sb_res", 64'(out_res), 64'(e.res));
          chk("sb_err", 64'(out_err), 64'(e.err));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        model(in_op, in_a, in_b, e);
        sbq.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_res;
      prev_err   = out_err;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: accepted now, result due exactly two cycles later.
  task automatic run1(input string nm, input logic [1:0] op, input lanes_t a, input lanes_t b,
                      input lanes_t er, input logic [NCH-1:0] ee);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    smp();
    chk({nm, "_in_ready"}, 64'(in_ready), 64'(1'b1));
    adv();
    in_valid = 1'b0;
    smp();
    chk({nm, "_early_valid"}, 64'(out_valid), 64'(1'b0));
    adv();
    smp();
    chk({nm, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({nm, "_res"}, 64'(out_res), 64'(er));
    chk({nm, "_err"}, 64'(out_err), 64'(ee));
    adv();
  endtask

  initial begin
    vec_t   tbl[8];
    lanes_t la, lb;
    int     sent, base, cyc;
    logic   acc_ok;
    logic [1:0] seq_op[4];
    int     seq_v[4];
    int     seq_r[4];

    tbl[0] = '{OP_ADD, {8'd5, 8'd10, 8'd0, 8'd7}, {8'd6, 8'd10, 8'd4, 8'd6}, {8'd0, 8'd9, 8'd4, 8'd2}};
    tbl[1] = '{OP_SUB, {8'd0, 8'd10, 8'd4, 8'd3}, {8'd1, 8'd0, 8'd4, 8'd5}, {8'd10, 8'd10, 8'd0, 8'd9}};
    tbl[2] = '{OP_CLR, {8'd3, 8'd3, 8'd3, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0}};
    tbl[3] = '{OP_ACC, {8'd10, 8'd0, 8'd1, 8'd6}, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd10, 8'd0, 8'd1, 8'd6}};
    tbl[4] = '{OP_ACC, {8'd10, 8'd3, 8'd2, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd9, 8'd3, 8'd3, 8'd2}};
    tbl[5] = '{OP_ACC, {8'd1, 8'd8, 8'd3, 8'd9}, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd10, 8'd0, 8'd6, 8'd0}};
    tbl[6] = '{OP_ADD, {8'd10, 8'd10, 8'd1, 8'd0}, {8'd0, 8'd1, 8'd10, 8'd9}, {8'd10, 8'd0, 8'd0, 8'd9}};
    tbl[7] = '{OP_SUB, {8'd9, 8'd2, 8'd0, 8'd10}, {8'd9, 8'd7, 8'd0, 8'd10}, {8'd0, 8'd6, 8'd0, 8'd0}};

    for (int i = 0; i < NCH; i++) acc_m[i] = 0;
    rst = 1'b1; in_valid = 1'b0; in_op = OP_ADD; in_a = '0; in_b = '0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      smp();
      adv();
    end
    smp();
    chk("reset_out_valid", 64'(out_valid), 64'(1'b0));
    chk("reset_out_res", 64'(out_res), 64'(0));
    chk("reset_out_err", 64'(out_err), 64'(0));
    adv();
    rst = 1'b0;
    smp();
    chk("post_reset_in_ready", 64'(in_ready), 64'(1'b1));
    adv();

    for (int k = 0; k < 8; k++)
      run1($sformatf("tbl%0d", k), tbl[k].op, tcl(tbl[k].a), tcl(tbl[k].b), tcl(tbl[k].r), '0);

    // Back-to-back CLR, ACC 6, 7, 9: results on consecutive cycles.
    seq_op = '{OP_CLR, OP_ACC, OP_ACC, OP_ACC};
    seq_v  = '{0, 6, 7, 9};
    seq_r  = '{0, 6, 2, 0};
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_op = seq_op[c]; in_a = splat(seq_v[c]); in_b = '0;
      end else begin
        in_valid = 1'b0;
      end
      smp();
      if (c < 4) chk($sformatf("b2b_in_ready%0d", c), 64'(in_ready), 64'(1'b1));
      if (c >= 2) begin
        chk($sformatf("b2b_valid%0d", c), 64'(out_valid), 64'(1'b1));
        chk($sformatf("b2b_res%0d", c), 64'(out_res), 64'(splat(seq_r[c-2])));
      end
      adv();
    end

    // Invalid code on lane 1 for ADD, then for ACC.
    run1("inv_clr", OP_CLR, '0, '0, '0, '0);
    run1("inv_acc0", OP_ACC, tcl({8'd4, 8'd3, 8'd2, 8'd1}), '0, tcl({8'd4, 8'd3, 8'd2, 8'd1}), '0);
    la = tcl({8'd9, 8'd3, 8'd0, 8'd1});
    la[1] = 10'b0000100111;
    lb = tcl({8'd9, 8'd8, 8'd2, 8'd2});
    run1("inv_add", OP_ADD, la, lb, tcl({8'd7, 8'd0, 8'd0, 8'd3}), 4'b0010);
    la = tcl({8'd0, 8'd1, 8'd0, 8'd2});
    la[1] = 10'b0000100111;
    run1("inv_acc1", OP_ACC, la, '0, tcl({8'd4, 8'd4, 8'd0, 8'd3}), 4'b0010);
    run1("inv_acc2", OP_ACC, '0, '0, tcl({8'd4, 8'd4, 8'd2, 8'd3}), '0);

    // Streaming 20 ADDs under a toggling then stalled sink.
    sent = 0; base = n_out; cyc = 0;
    in_op = OP_ADD;
    for (int i = 0; i < NCH; i++) begin la[i] = rlane(); lb[i] = rlane(); end
    la = splat(3) ^ '0; la = tcl({8'd1, 8'd2, 8'd3, 8'd4});
    while ((n_out - base < 20) && (cyc < 300)) begin
      out_ready = (cyc < 12) ? ((cyc % 2) == 0) : (cyc >= 17);
      in_valid  = (sent < 20);
      in_a = la; in_b = lb;
      smp();
      if (cyc == 16) begin
        chk("stream_full_in_ready", 64'(in_ready), 64'(1'b0));
        chk("stream_full_out_valid", 64'(out_valid), 64'(1'b1));
      end
      acc_ok = in_valid && in_ready;
      adv();
      if (acc_ok) begin
        sent++;
        for (int i = 0; i < NCH; i++) begin
          la[i] = W'(bin2tc(int'($urandom_range(0, M-1))));
          lb[i] = W'(bin2tc(int'($urandom_range(0, M-1))));
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", 64'(n_out - base), 64'(20));

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    run_two: for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_op = OP_ADD; in_a = splat(c + 1); in_b = splat(2);
      smp();
      adv();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    smp();
    adv();
    rst = 1'b0;
    out_ready = 1'b1;
    smp();
    chk("rst_flush_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_release_in_ready", 64'(in_ready), 64'(1'b1));
    adv();
    for (int c = 0; c < 4; c++) begin
      smp();
      chk($sformatf("rst_no_emit%0d", c), 64'(out_valid), 64'(1'b0));
      adv();
    end
    run1("rst_acc3", OP_ACC, splat(3), '0, splat(3), '0);

    // Random mixed traffic against the reference.
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      smp();
      acc_ok = in_valid && in_ready;
      adv();
      if (!in_valid || acc_ok) begin
        in_valid = ($urandom_range(0, 4) != 0);
        in_op    = 2'($urandom_range(0, 3));
        for (int i = 0; i < NCH; i++) begin la[i] = rlane(); lb[i] = rlane(); end
        in_a = la;
        in_b = lb;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; (c < 20) && (sbq.size() != 0); c++) begin
      smp();
      adv();
    end
    chk("drain_empty", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
